// File: rtl/fp_compare_unit_pkg.sv
// Shared types for the FP compare execution unit: operand/result widths,
// comparator command encoding, fflags layout and the per-stage payload structs.
package fp_compare_unit_pkg;

    localparam int FPC_EXPONENT_WIDTH = 8;
    localparam int FPC_FRACTION_WIDTH = 23;
    localparam int FPC_WIDTH          = 1 + FPC_EXPONENT_WIDTH + FPC_FRACTION_WIDTH;
    localparam int FPC_TAG_WIDTH      = 5;
    localparam int FPC_XLEN           = 32;

    typedef logic [FPC_XLEN-1:0] word_t;

    // RISC-V fcsr order, MSB first: NV DZ OF UF NX.
    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

    typedef enum logic [2:0] {
        CMP_EQ  = 3'd0,
        CMP_LT  = 3'd1,
        CMP_LE  = 3'd2,
        CMP_MIN = 3'd3,
        CMP_MAX = 3'd4
    } FpComparatorCommand;

    typedef struct packed {
        FpComparatorCommand       command;
        logic [FPC_WIDTH-1:0]     src1;
        logic [FPC_WIDTH-1:0]     src2;
        logic [FPC_TAG_WIDTH-1:0] tag;
    } FpCompareReq;

    typedef struct packed {
        logic [FPC_TAG_WIDTH-1:0] tag;
        logic                     is_fp;
        word_t                    int_result;
        logic [FPC_WIDTH-1:0]     fp_result;
        fflags_t                  flags;
    } FpCompareResp;

    function automatic logic cmd_is_fp(input FpComparatorCommand cmd);
        return (cmd == CMP_MIN) || (cmd == CMP_MAX);
    endfunction

endpackage

// File: rtl/fp_compare_unit_comparator.sv
// Combinational FP comparator: FEQ/FLT/FLE produce a 0/1 word, FMIN/FMAX an FP
// value, each with its invalid-operation flag. Unknown commands yield zeros.
module fp_compare_unit_comparator
    import fp_compare_unit_pkg::*;
#(
    parameter int EXPONENT_WIDTH = FPC_EXPONENT_WIDTH,
    parameter int FRACTION_WIDTH = FPC_FRACTION_WIDTH
) (
    input  FpComparatorCommand                             command,
    input  logic [EXPONENT_WIDTH+FRACTION_WIDTH:0]         src1,
    input  logic [EXPONENT_WIDTH+FRACTION_WIDTH:0]         src2,
    output word_t                                          int_result,
    output logic [EXPONENT_WIDTH+FRACTION_WIDTH:0]         fp_result,
    output fflags_t                                        flags
);

    localparam int WIDTH = 1 + EXPONENT_WIDTH + FRACTION_WIDTH;
    localparam int MAG_W = WIDTH - 1;
    localparam logic [WIDTH-1:0] CANON_NAN =
        {1'b0, {EXPONENT_WIDTH{1'b1}}, 1'b1, {(FRACTION_WIDTH-1){1'b0}}};

    logic             a_sign, b_sign;
    logic [MAG_W-1:0] a_mag, b_mag;
    logic             a_nan, b_nan, a_snan, b_snan;
    logic             any_nan, any_snan;
    logic             equal, lt_order;

    assign a_sign   = src1[WIDTH-1];
    assign b_sign   = src2[WIDTH-1];
    assign a_mag    = src1[MAG_W-1:0];
    assign b_mag    = src2[MAG_W-1:0];
    assign a_nan    = (&src1[WIDTH-2:FRACTION_WIDTH]) && (|src1[FRACTION_WIDTH-1:0]);
    assign b_nan    = (&src2[WIDTH-2:FRACTION_WIDTH]) && (|src2[FRACTION_WIDTH-1:0]);
    assign a_snan   = a_nan && !src1[FRACTION_WIDTH-1];
    assign b_snan   = b_nan && !src2[FRACTION_WIDTH-1];
    assign any_nan  = a_nan || b_nan;
    assign any_snan = a_snan || b_snan;
    assign equal    = (src1 == src2) || ((a_mag == '0) && (b_mag == '0));

    // Ordering that places -0 below +0; FLT masks it with !equal, FMIN/FMAX rely on it.
    assign lt_order = (a_sign != b_sign) ? a_sign
                    : (a_sign ? (a_mag > b_mag) : (a_mag < b_mag));

    always_comb begin
        int_result = '0;
        fp_result  = '0;
        flags      = '0;
        case (command)
            CMP_EQ: begin
                int_result[0] = !any_nan && equal;
                flags.nv      = any_snan;
            end
            CMP_LT: begin
                int_result[0] = !any_nan && lt_order && !equal;
                flags.nv      = any_nan;
            end
            CMP_LE: begin
                int_result[0] = !any_nan && (lt_order || equal);
                flags.nv      = any_nan;
            end
            CMP_MIN, CMP_MAX: begin
                flags.nv = any_snan;
                if (a_nan && b_nan) begin
                    fp_result = CANON_NAN;
                end else if (a_nan) begin
                    fp_result = src2;
                end else if (b_nan) begin
                    fp_result = src1;
                end else if (command == CMP_MIN) begin
                    fp_result = lt_order ? src1 : src2;
                end else begin
                    fp_result = lt_order ? src2 : src1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/fp_compare_unit.sv
// Two-stage handshaked shell around the FP comparator: S1 holds the accepted
// operands, S2 the tagged result; also keeps the sticky fflags accumulator.
module fp_compare_unit
    import fp_compare_unit_pkg::*;
#(
    parameter int EXPONENT_WIDTH = FPC_EXPONENT_WIDTH,
    parameter int FRACTION_WIDTH = FPC_FRACTION_WIDTH,
    parameter int WIDTH          = 1 + EXPONENT_WIDTH + FRACTION_WIDTH,
    parameter int TAG_WIDTH      = FPC_TAG_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 reqValid,
    output logic                 reqReady,
    input  FpComparatorCommand   reqCommand,
    input  logic [WIDTH-1:0]     reqSrc1,
    input  logic [WIDTH-1:0]     reqSrc2,
    input  logic [TAG_WIDTH-1:0] reqTag,
    output logic                 respValid,
    input  logic                 respReady,
    output logic [TAG_WIDTH-1:0] respTag,
    output logic                 respIsFp,
    output word_t                respIntResult,
    output logic [WIDTH-1:0]     respFpResult,
    output fflags_t              respFlags,
    input  logic                 fflagsClear,
    output fflags_t              fflagsAccum,
    output logic                 busy
);

    logic         s1_valid_q, s1_valid_d;
    FpCompareReq  s1_req_q, s1_req_d;
    logic         s2_valid_q, s2_valid_d;
    FpCompareResp s2_resp_q, s2_resp_d;
    fflags_t      fflags_accum_q, fflags_accum_d;

    logic         s2_free, accept, s1_advance, retire;
    word_t        cmp_int;
    logic [WIDTH-1:0] cmp_fp;
    fflags_t      cmp_flags;

    fp_compare_unit_comparator #(
        .EXPONENT_WIDTH (EXPONENT_WIDTH),
        .FRACTION_WIDTH (FRACTION_WIDTH)
    ) u_comparator (
        .command    (s1_req_q.command),
        .src1       (s1_req_q.src1),
        .src2       (s1_req_q.src2),
        .int_result (cmp_int),
        .fp_result  (cmp_fp),
        .flags      (cmp_flags)
    );

    // Valid/ready: a transfer happens on any cycle where valid && ready at the
    // clock edge; the payload is held stable while valid && !ready.
    assign s2_free    = !s2_valid_q || respReady;
    assign reqReady   = !flush && (!s1_valid_q || s2_free);
    assign accept     = reqValid && reqReady;
    assign s1_advance = s1_valid_q && s2_free;
    assign retire     = s2_valid_q && respReady;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_req_d   = s1_req_q;
        s2_valid_d = s2_valid_q;
        s2_resp_d  = s2_resp_q;

        if (accept) begin
            s1_req_d.command = reqCommand;
            s1_req_d.src1    = reqSrc1;
            s1_req_d.src2    = reqSrc2;
            s1_req_d.tag     = reqTag;
        end
        if (s1_advance) begin
            s2_resp_d.tag        = s1_req_q.tag;
            s2_resp_d.is_fp      = cmd_is_fp(s1_req_q.command);
            s2_resp_d.int_result = cmp_int;
            s2_resp_d.fp_result  = cmp_fp;
            s2_resp_d.flags      = cmp_flags;
        end

        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (accept) begin
                s1_valid_d = 1'b1;
            end else if (s1_advance) begin
                s1_valid_d = 1'b0;
            end
            if (s1_advance) begin
                s2_valid_d = 1'b1;
            end else if (retire) begin
                s2_valid_d = 1'b0;
            end
        end

        // A retire in the clear cycle still lands in the accumulator.
        fflags_accum_d = (fflagsClear ? fflags_t'('0) : fflags_accum_q)
                       | (retire ? s2_resp_q.flags : fflags_t'('0));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q     <= 1'b0;
            s1_req_q       <= '0;
            s2_valid_q     <= 1'b0;
            s2_resp_q      <= '0;
            fflags_accum_q <= '0;
        end else begin
            s1_valid_q     <= s1_valid_d;
            s1_req_q       <= s1_req_d;
            s2_valid_q     <= s2_valid_d;
            s2_resp_q      <= s2_resp_d;
            fflags_accum_q <= fflags_accum_d;
        end
    end

    assign respValid     = s2_valid_q;
    assign respTag       = s2_resp_q.tag;
    assign respIsFp      = s2_resp_q.is_fp;
    assign respIntResult = s2_resp_q.int_result;
    assign respFpResult  = s2_resp_q.fp_result;
    assign respFlags     = s2_resp_q.flags;
    assign fflagsAccum   = fflags_accum_q;
    assign busy          = s1_valid_q || s2_valid_q;

endmodule

// File: tb/tb_fp_compare_unit.sv
// Directed bench for fp_compare_unit: latency, results/flags, backpressure,
// flush, fflags accumulate/clear and asynchronous reset mid-stream.
module tb_fp_compare_unit;
    import fp_compare_unit_pkg::*;

    localparam int RW = 75;

    logic               clk = 1'b0;
    logic               rst;
    logic               flush;
    logic               req_valid;
    logic               req_ready;
    FpComparatorCommand req_command;
    logic [31:0]        req_src1, req_src2;
    logic [4:0]         req_tag;
    logic               resp_valid;
    logic               resp_ready;
    logic [4:0]         resp_tag;
    logic               resp_is_fp;
    word_t              resp_int_result;
    logic [31:0]        resp_fp_result;
    fflags_t            resp_flags;
    logic               fflags_clear;
    fflags_t            fflags_accum;
    logic               busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [RW-1:0] exp_q[$];

    fp_compare_unit dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .reqValid      (req_valid),
        .reqReady      (req_ready),
        .reqCommand    (req_command),
        .reqSrc1       (req_src1),
        .reqSrc2       (req_src2),
        .reqTag        (req_tag),
        .respValid     (resp_valid),
        .respReady     (resp_ready),
        .respTag       (resp_tag),
        .respIsFp      (resp_is_fp),
        .respIntResult (resp_int_result),
        .respFpResult  (resp_fp_result),
        .respFlags     (resp_flags),
        .fflagsClear   (fflags_clear),
        .fflagsAccum   (fflags_accum),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [RW-1:0] resp_vec();
        return {resp_tag, resp_is_fp, resp_int_result, resp_fp_result, resp_flags};
    endfunction

    function automatic logic [RW-1:0] mk(input logic [4:0] tag, input logic is_fp,
                                         input logic int_r, input logic [31:0] fp_r,
                                         input logic nv);
        return {tag, is_fp, {31'd0, int_r}, fp_r, nv, 4'b0000};
    endfunction

    task automatic drive(input FpComparatorCommand c, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] t);
        req_valid   = 1'b1;
        req_command = c;
        req_src1    = a;
        req_src2    = b;
        req_tag     = t;
    endtask

    // Present one op at a negedge into an empty front stage; returns one cycle later.
    task automatic issue(input FpComparatorCommand c, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] t);
        @(negedge clk);
        drive(c, a, b, t);
        #1;
        check("issue_ready", req_ready, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        fflags_clear = 1'b1;
        @(negedge clk);
        fflags_clear = 1'b0;
        #1;
        check("accum_cleared", fflags_accum, 5'h00);
    endtask

    FpComparatorCommand op_cmd[4];
    logic [31:0]        op_a[4];
    logic [31:0]        op_b[4];
    logic [4:0]         op_tag[4];

    initial begin
        rst          = 1'b0;
        flush        = 1'b0;
        req_valid    = 1'b0;
        req_command  = CMP_EQ;
        req_src1     = '0;
        req_src2     = '0;
        req_tag      = '0;
        resp_ready   = 1'b0;
        fflags_clear = 1'b0;

        // Reset state
        #1;
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_accum", fflags_accum, 5'h00);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // 1: FLT 1.0 < 2.0, two-edge latency
        resp_ready = 1'b1;
        issue(CMP_LT, 32'h3F800000, 32'h40000000, 5'd3);
        #1;
        check("t1_not_yet", resp_valid, 1'b0);
        @(negedge clk);
        #1;
        check("t1_valid", resp_valid, 1'b1);
        check("t1_resp", resp_vec(), mk(5'd3, 1'b0, 1'b1, 32'h0, 1'b0));
        @(negedge clk);
        #1;
        check("t1_drained", {resp_valid, busy}, 2'b00);

        // Unknown command with an sNaN operand: everything zero
        issue(FpComparatorCommand'(3'd7), 32'h7F800001, 32'h3F800000, 5'd5);
        @(negedge clk);
        #1;
        check("unk_resp", {resp_valid, resp_vec()}, {1'b1, mk(5'd5, 1'b0, 1'b0, 32'h0, 1'b0)});
        @(negedge clk);
        #1;
        check("unk_accum", fflags_accum, 5'h00);

        // 2: FMAX 1.0 vs sNaN -> 1.0 with NV
        issue(CMP_MAX, 32'h3F800000, 32'h7F800001, 5'd7);
        @(negedge clk);
        #1;
        check("t2_resp", resp_vec(), mk(5'd7, 1'b1, 1'b0, 32'h3F800000, 1'b1));
        @(negedge clk);
        #1;
        check("t2_accum", fflags_accum, 5'h10);
        pulse_clear();

        // 3: four back-to-back ops under backpressure
        op_cmd = '{CMP_EQ, CMP_LE, CMP_MIN, CMP_LT};
        op_a   = '{32'h40000000, 32'hBF800000, 32'h80000000, 32'h7FC00000};
        op_b   = '{32'h40000000, 32'h3F800000, 32'h00000000, 32'h3F800000};
        op_tag = '{5'd10, 5'd11, 5'd12, 5'd13};
        exp_q.push_back(mk(5'd10, 1'b0, 1'b1, 32'h0, 1'b0));
        exp_q.push_back(mk(5'd11, 1'b0, 1'b1, 32'h0, 1'b0));
        exp_q.push_back(mk(5'd12, 1'b1, 1'b0, 32'h80000000, 1'b0));
        exp_q.push_back(mk(5'd13, 1'b0, 1'b0, 32'h0, 1'b1));
        resp_ready = 1'b0;
        @(negedge clk);
        drive(op_cmd[0], op_a[0], op_b[0], op_tag[0]);
        #1;
        check("t3_rdy0", req_ready, 1'b1);
        @(negedge clk);
        drive(op_cmd[1], op_a[1], op_b[1], op_tag[1]);
        #1;
        check("t3_rdy1", req_ready, 1'b1);
        @(negedge clk);
        drive(op_cmd[2], op_a[2], op_b[2], op_tag[2]);
        #1;
        check("t3_stall_rdy", req_ready, 1'b0);
        check("t3_s2_valid", resp_valid, 1'b1);
        @(negedge clk);
        #1;
        check("t3_hold_rdy", req_ready, 1'b0);
        check("t3_hold_resp", resp_vec(), exp_q[0]);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            resp_ready = 1'b1;
            if (i + 2 < 4) drive(op_cmd[i+2], op_a[i+2], op_b[i+2], op_tag[i+2]);
            else req_valid = 1'b0;
            #1;
            if (i == 0) check("t3_rdy_back", req_ready, 1'b1);
            check("t3_valid", resp_valid, 1'b1);
            check("t3_resp", resp_vec(), exp_q.pop_front());
        end
        @(negedge clk);
        #1;
        check("t3_empty", {resp_valid, busy}, 2'b00);
        check("t3_accum", fflags_accum, 5'h10);
        pulse_clear();

        // 4: flush with two sNaN ops in flight
        resp_ready = 1'b0;
        @(negedge clk);
        drive(CMP_EQ, 32'h7F800001, 32'h3F800000, 5'd20);
        @(negedge clk);
        drive(CMP_MAX, 32'h7F800001, 32'h7FA00000, 5'd21);
        @(negedge clk);
        drive(CMP_LT, 32'h3F800000, 32'h40000000, 5'd22);
        flush = 1'b1;
        #1;
        check("t4_flush_rdy", req_ready, 1'b0);
        check("t4_busy_pre", busy, 1'b1);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("t4_post_valid", resp_valid, 1'b0);
        check("t4_post_busy", busy, 1'b0);
        check("t4_post_accum", fflags_accum, 5'h00);
        check("t4_post_rdy", req_ready, 1'b1);
        @(negedge clk);
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        #1;
        check("t4_s1_only", {resp_valid, busy}, 2'b01);
        @(negedge clk);
        #1;
        check("t4_resp", {resp_valid, resp_vec()}, {1'b1, mk(5'd22, 1'b0, 1'b1, 32'h0, 1'b0)});
        @(negedge clk);
        #1;
        check("t4_done", {resp_valid, fflags_accum}, 6'h00);

        // 5: clear coinciding with a retire
        resp_ready = 1'b1;
        issue(CMP_LT, 32'h7FC00000, 32'h3F800000, 5'd1);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("t5_accum_nv", fflags_accum, 5'h10);
        resp_ready = 1'b0;
        issue(CMP_EQ, 32'h3F800000, 32'h3F800000, 5'd2);
        @(negedge clk);
        #1;
        check("t5_b_valid", resp_valid, 1'b1);
        fflags_clear = 1'b1;
        resp_ready   = 1'b1;
        @(negedge clk);
        fflags_clear = 1'b0;
        resp_ready   = 1'b0;
        #1;
        check("t5_clear_clean", fflags_accum, 5'h00);
        check("t5_b_retired", resp_valid, 1'b0);
        issue(CMP_LT, 32'h7FC00000, 32'h3F800000, 5'd3);
        @(negedge clk);
        #1;
        check("t5_c_valid", resp_valid, 1'b1);
        fflags_clear = 1'b1;
        resp_ready   = 1'b1;
        @(negedge clk);
        fflags_clear = 1'b0;
        #1;
        check("t5_clear_nv", fflags_accum, 5'h10);

        // 6: asynchronous reset with both stages full
        resp_ready = 1'b0;
        @(negedge clk);
        drive(CMP_EQ, 32'h3F800000, 32'h3F800000, 5'd25);
        @(negedge clk);
        drive(CMP_MIN, 32'h3F800000, 32'h40000000, 5'd26);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check("t6_full", {resp_valid, busy}, 2'b11);
        #2;
        rst = 1'b0;
        #1;
        check("t6_rst_valid", resp_valid, 1'b0);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_rdy", req_ready, 1'b1);
        check("t6_rst_accum", fflags_accum, 5'h00);
        check("t6_rst_payload", resp_vec(), {RW{1'b0}});
        flush = 1'b1;
        #1;
        check("t6_rst_flush_rdy", req_ready, 1'b0);
        flush = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst        = 1'b1;
        resp_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            check("t6_no_stale", resp_valid, 1'b0);
        end
        issue(CMP_EQ, 32'h40000000, 32'h40000000, 5'd9);
        @(negedge clk);
        #1;
        check("t6_resp", {resp_valid, resp_vec()}, {1'b1, mk(5'd9, 1'b0, 1'b1, 32'h0, 1'b0)});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
